// File: rtl/audio_dac_serializer.sv
// Stereo I2S transmitter for the WM8731 DAC path.
// Left/right sample pairs arrive through a valid/ready handshake into a small FIFO.
// They are shifted out MSB-first on AUD_DACDAT, following the codec-mastered AUD_BCLK and
// AUD_DACLRCK. Both codec clocks are sampled as data on CLOCK_50.
//
// Ports:
//   CLOCK_50        system clock (only clock)
//   RESET           asynchronous, active-high reset
//   sample_left     left sample, two's complement
//   sample_right    right sample, two's complement
//   sample_valid    pair present on sample_left/sample_right
//   sample_ready    FIFO not full (combinational)
//   AUD_BCLK        codec bit clock (asynchronous input)
//   AUD_DACLRCK     codec frame clock: low = left, high = right
//   AUD_DACDAT      registered serial data to the codec
//   fifo_level      current FIFO occupancy in stereo pairs
//   underrun_count  saturating count of frames sent with an empty FIFO
module audio_dac_serializer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    input  logic [DATA_WIDTH-1:0]         sample_left,
    input  logic [DATA_WIDTH-1:0]         sample_right,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [AW:0] FullLevel = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StArm, StShift, StPad} state_e;

    // ---------------- codec clock synchronizers ----------------
    logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
    logic lr_meta_q, lr_sync_q, lr_prev_q;
    logic bclk_fall, lr_fall, lr_rise;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            bclk_meta_q <= 1'b0;
            bclk_sync_q <= 1'b0;
            bclk_prev_q <= 1'b0;
            lr_meta_q   <= 1'b0;
            lr_sync_q   <= 1'b0;
            lr_prev_q   <= 1'b0;
        end else begin
            bclk_meta_q <= AUD_BCLK;
            bclk_sync_q <= bclk_meta_q;
            bclk_prev_q <= bclk_sync_q;
            lr_meta_q   <= AUD_DACLRCK;
            lr_sync_q   <= lr_meta_q;
            lr_prev_q   <= lr_sync_q;
        end
    end

    assign bclk_fall = ~bclk_sync_q & bclk_prev_q;
    assign lr_fall   = ~lr_sync_q & lr_prev_q;
    assign lr_rise   = lr_sync_q & ~lr_prev_q;

    // ---------------- sample FIFO, entries are {left, right} ----------------
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             level_q;
    logic                    full, empty, push, pop;
    logic [2*DATA_WIDTH-1:0] rd_data;

    assign full         = (level_q == FullLevel);
    assign empty        = (level_q == '0);
    assign sample_ready = ~full;
    assign push         = sample_valid & ~full;
    assign pop          = lr_fall & ~empty;
    assign rd_data      = mem_q[rd_ptr_q];

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sample_left, sample_right};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- frame / bit sequencer ----------------
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] rhold_q, rhold_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic                  dac_q, dac_d;
    logic [7:0]            underrun_q, underrun_d;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            rhold_q    <= '0;
            bitcnt_q   <= '0;
            dac_q      <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            rhold_q    <= rhold_d;
            bitcnt_q   <= bitcnt_d;
            dac_q      <= dac_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        rhold_d    = rhold_q;
        bitcnt_d   = bitcnt_q;
        dac_d      = dac_q;
        underrun_d = underrun_q;

        // LR edges take priority: a coincident BCLK fall is the I2S delay slot.
        if (lr_fall) begin
            state_d = StArm;
            dac_d   = 1'b0;
            if (!empty) begin
                sh_d    = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
                rhold_d = rd_data[DATA_WIDTH-1:0];
            end else begin
                sh_d    = '0;
                rhold_d = '0;
                if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
            end
        end else if (lr_rise && state_q != StIdle) begin
            // Idle ignores rises so a word is never started mid-frame.
            state_d = StArm;
            dac_d   = 1'b0;
            sh_d    = rhold_q;
        end else if (bclk_fall) begin
            case (state_q)
                StArm: begin
                    dac_d    = sh_q[DATA_WIDTH-1];
                    sh_d     = sh_q << 1;
                    bitcnt_d = CW'(DATA_WIDTH - 1);
                    state_d  = StShift;
                end
                StShift: begin
                    if (bitcnt_q == '0) begin
                        dac_d   = 1'b0;
                        state_d = StPad;
                    end else begin
                        dac_d    = sh_q[DATA_WIDTH-1];
                        sh_d     = sh_q << 1;
                        bitcnt_d = bitcnt_q - CW'(1);
                    end
                end
                default: begin
                    dac_d = 1'b0;
                end
            endcase
        end
    end

    assign AUD_DACDAT     = dac_q;
    assign fifo_level     = level_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: a codec model generates BCLK/LRCK and samples
// AUD_DACDAT on BCLK rises; a frame-level reference model predicts each half-frame word.
module tb_audio_dac_serializer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          CLOCK_50     = 1'b0;
    logic          RESET        = 1'b0;
    logic [DW-1:0] sample_left  = '0;
    logic [DW-1:0] sample_right = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          AUD_BCLK     = 1'b1;
    logic          AUD_DACLRCK  = 1'b1;
    logic          AUD_DACDAT;
    logic [2:0]    fifo_level;
    logic [7:0]    underrun_count;

    audio_dac_serializer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET         (RESET),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .AUD_BCLK      (AUD_BCLK),
        .AUD_DACLRCK   (AUD_DACLRCK),
        .AUD_DACDAT    (AUD_DACDAT),
        .fifo_level    (fifo_level),
        .underrun_count(underrun_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_tests = 0;
    int n_fail  = 0;

    // Codec generator controls (written by stimulus only)
    int half_len = 32;  // BCLKs per LR half
    int bhalf    = 8;   // CLOCK_50 cycles per BCLK phase
    bit run      = 1'b0;
    // Codec generator state (written by generator only)
    bit running  = 1'b0;
    int bidx     = 31;
    int ph       = 0;
    int n_lrfall = 0;

    // Reference model
    logic [2*DW-1:0] mq[$];    // accepted pairs not yet framed
    logic [DW-1:0]   expq[$];  // words the codec should hear, in order
    int              m_underrun = 0;
    int              reset_epoch = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Frame-level behaviour at each LR fall: next pair if any, else silence + underrun.
    task automatic model_lr_fall();
        logic [2*DW-1:0] p;
        if (!RESET) begin
            if (mq.size() > 0) begin
                p = mq.pop_front();
                expq.push_back(p[2*DW-1:DW]);
                expq.push_back(p[DW-1:0]);
            end else begin
                expq.push_back('0);
                expq.push_back('0);
                if (m_underrun < 255) m_underrun++;
            end
        end
    endtask

    // Codec clock generator; LRCK changes on BCLK falls, stops after a right half.
    initial begin : codec_gen
        forever begin
            @(posedge CLOCK_50);
            #3;
            if (!running) begin
                if (run) begin
                    running     = 1'b1;
                    ph          = 0;
                    bidx        = half_len - 1;
                    AUD_BCLK    = 1'b1;
                    AUD_DACLRCK = 1'b1;
                end
            end else begin
                ph++;
                if (ph == bhalf) begin
                    ph = 0;
                    if (AUD_BCLK) begin
                        AUD_BCLK = 1'b0;
                        bidx++;
                        if (bidx == half_len) begin
                            bidx        = 0;
                            AUD_DACLRCK = ~AUD_DACLRCK;
                            if (!AUD_DACLRCK) begin
                                n_lrfall++;
                                model_lr_fall();
                            end
                        end
                    end else begin
                        AUD_BCLK = 1'b1;
                        if (!run && AUD_DACLRCK && bidx == half_len - 1) running = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: codec samples on BCLK rise; one word comparison per complete half-frame.
    initial begin : monitor
        logic [63:0] cap;
        logic [63:0] ex;
        logic [DW-1:0] w;
        bit in_half;
        int ep;
        cap = '0;
        in_half = 1'b0;
        ep = 0;
        forever begin
            @(posedge AUD_BCLK);
            if (bidx == 0) begin
                cap     = '0;
                in_half = 1'b1;
                ep      = reset_epoch;
            end
            cap[bidx] = AUD_DACDAT;
            if (in_half && bidx == half_len - 1) begin
                in_half = 1'b0;
                if (ep == reset_epoch) begin
                    if (expq.size() > 0) w = expq.pop_front();
                    else w = '0;
                    ex = '0;
                    for (int k = 1; k < half_len && k <= DW; k++) ex[k] = w[DW-k];
                    if (AUD_DACLRCK) begin
                        check("right_word", cap, ex);
                    end else begin
                        check("left_word", cap, ex);
                        check("underrun_track", underrun_count, m_underrun);
                        check("level_track", fifo_level, mq.size());
                    end
                end
            end
        end
    end

    function automatic bit push_blocked();
        // Keep pushes clear of the LR-fall pop so the model's frame order is unambiguous.
        return (run && !running) ||
               (running && ((!AUD_DACLRCK && bidx == 0) ||
                            (AUD_DACLRCK && bidx == half_len - 1)));
    endfunction

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        for (int t = 0; t < 20000; t++) begin
            @(negedge CLOCK_50);
            if (sample_ready && !push_blocked()) begin
                sample_left  = l;
                sample_right = r;
                sample_valid = 1'b1;
                @(posedge CLOCK_50);
                mq.push_back({l, r});
                #1 sample_valid = 1'b0;
                return;
            end
        end
        timeout("push");
    endtask

    task automatic assert_reset();
        @(negedge CLOCK_50);
        RESET = 1'b1;
        reset_epoch++;
        mq.delete();
        expq.delete();
        m_underrun = 0;
    endtask

    task automatic release_reset();
        @(negedge CLOCK_50);
        RESET = 1'b0;
    endtask

    task automatic start_codec(input int h, input int bh);
        half_len = h;
        bhalf    = bh;
        run      = 1'b1;
    endtask

    task automatic stop_codec();
        run = 1'b0;
        for (int t = 0; t < 20000 && (running || run); t++) @(negedge CLOCK_50);
        if (running) timeout("codec_stop");
    endtask

    task automatic wait_lrfalls(input int target);
        for (int t = 0; t < 40000 && n_lrfall < target; t++) @(negedge CLOCK_50);
        if (n_lrfall < target) timeout("lr_fall_wait");
    endtask

    task automatic wait_pos(input bit lr, input int idx);
        for (int t = 0; t < 20000; t++) begin
            @(negedge CLOCK_50);
            if (running && AUD_DACLRCK == lr && bidx == idx) return;
        end
        timeout("codec_position");
    endtask

    initial begin : watchdog
        #2_400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int f0;
        logic [DW-1:0] rl, rr;
        logic [DW-1:0] mid_l;

        // Reset values
        assert_reset();
        @(negedge CLOCK_50);
        check("rst_dacdat", AUD_DACDAT, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_underrun", underrun_count, 0);
        release_reset();

        // Basic frame
        push_pair(16'hA5C3, 16'h3C5A);
        check("basic_level", fifo_level, 1);
        f0 = n_lrfall;
        start_codec(32, 8);
        wait_lrfalls(f0 + 1);
        stop_codec();
        check("basic_underrun", underrun_count, 0);

        // Backpressure with codec stopped, then drain
        assert_reset();
        release_reset();
        for (int k = 0; k < 4; k++) begin
            push_pair(16'h1111 * (k + 1), 16'h0F0F ^ (16'h0101 * k));
            check("bp_ready", sample_ready, (k < 3));
            check("bp_level", fifo_level, k + 1);
        end
        f0 = n_lrfall;
        start_codec(32, 8);
        for (int t = 0; t < 20000 && !sample_ready; t++) @(negedge CLOCK_50);
        check("bp_ready_after_pop", sample_ready, 1);
        check("bp_level_after_pop", fifo_level, 3);
        push_pair(16'h5555, 16'hAAAA);
        push_pair(16'h8001, 16'h7FFE);
        wait_lrfalls(f0 + 6);
        stop_codec();
        check("bp_drained", fifo_level, 0);

        // Underrun and saturation
        assert_reset();
        release_reset();
        f0 = n_lrfall;
        start_codec(32, 8);
        wait_lrfalls(f0 + 3);
        stop_codec();
        check("underrun_3", underrun_count, 3);
        f0 = n_lrfall;
        start_codec(4, 6);
        wait_lrfalls(f0 + 300);
        stop_codec();
        check("underrun_sat", underrun_count, 255);

        // Startup alignment: release reset with LRCK high mid-frame
        assert_reset();
        f0 = n_lrfall;
        start_codec(32, 8);
        wait_pos(1'b1, 10);
        release_reset();
        push_pair(16'hBEEF, 16'h1234);
        wait_lrfalls(f0 + 2);
        stop_codec();
        check("startup_underrun", underrun_count, 0);

        // Short frames: 12 BCLK per half
        assert_reset();
        release_reset();
        push_pair(16'hFFFF, 16'h8421);
        push_pair(16'h1357, 16'hFEDC);
        push_pair(16'hC001, 16'h0FF0);
        f0 = n_lrfall;
        start_codec(12, 8);
        wait_lrfalls(f0 + 4);
        stop_codec();
        check("short_underrun", underrun_count, 1);

        // Reset in the middle of the left word (during bit 7)
        assert_reset();
        release_reset();
        mid_l = 16'hC3B5;
        push_pair(mid_l, 16'h6E6E);
        push_pair(16'h2222, 16'h3333);
        f0 = n_lrfall;
        start_codec(32, 8);
        wait_lrfalls(f0 + 1);
        wait_pos(1'b0, DW - 7);
        repeat (4) @(negedge CLOCK_50);
        check("mid_bit7", AUD_DACDAT, mid_l[7]);
        check("mid_level_before", fifo_level, 1);
        assert_reset();
        #1;
        check("mid_rst_dacdat", AUD_DACDAT, 0);
        check("mid_rst_level", fifo_level, 0);
        repeat (3) @(negedge CLOCK_50);
        release_reset();
        push_pair(16'h4D3C, 16'hB2A1);
        wait_lrfalls(n_lrfall + 2);
        stop_codec();

        // Randomized traffic at varying frame lengths
        assert_reset();
        release_reset();
        start_codec($urandom_range(18, 32), 8);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 700)) @(negedge CLOCK_50);
            rl = 16'($urandom);
            rr = 16'($urandom);
            push_pair(rl, rr);
        end
        for (int t = 0; t < 20000 && mq.size() > 0; t++) @(negedge CLOCK_50);
        if (mq.size() > 0) timeout("random_drain");
        wait_lrfalls(n_lrfall + 1);
        stop_codec();
        check("random_level", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Stereo I2S transmitter feeding the WM8731 codec DAC path on the DE2-115 audio keyboard. It accepts 16-bit left/right sample pairs from the tone-synthesis logic through a valid/ready handshake and buffers them in a small FIFO. It serializes them MSB-first onto AUD_DACDAT, following the codec-mastered AUD_BCLK and AUD_DACLRCK. Everything runs on CLOCK_50; the codec clocks are sampled as data.

## Interface
- DATA_WIDTH, 16: bits per channel sample.
- FIFO_DEPTH, 4: stereo-pair entries; power of two, ≥2.
- CLOCK_50  in  1  system clock; the block's only clock.
- RESET  in  1  asynchronous, active-high reset.
- sample_left  in  DATA_WIDTH  left sample, two's complement.
- sample_right  in  DATA_WIDTH  right sample, two's complement.
- sample_valid  in  1  pair present on sample_left/right.
- sample_ready  out  1  FIFO not full; combinational !full.
- AUD_BCLK  in  1  codec bit clock, asynchronous to CLOCK_50.
- AUD_DACLRCK  in  1  codec frame clock: low = left, high = right.
- AUD_DACDAT  out  1  serial data to codec, registered.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun_count  out  8  saturating count of frames sent with no data.

## Operation
- **Synchronizers.** AUD_BCLK and AUD_DACLRCK each pass through 2 flops, then a third "prev" flop.
  - bclk_fall = !b2 & bprev
  - lr_fall = !l2 & lprev
  - lr_rise = l2 & !lprev
- **FIFO.**
  - Width 2×DATA_WIDTH, {left,right}.
  - Push when sample_valid && sample_ready.
  - Pop only on lr_fall with FIFO non-empty.
  - A push and a pop in the same cycle leave fifo_level unchanged.
- **Frame load on lr_fall.**
  - FIFO non-empty: pop, load shift register with left, hold right in r_hold.
  - FIFO empty: load 0 into both, increment underrun_count (saturates at 255). A push arriving that cycle is stored, not used.
- **lr_rise.** Load shift register from r_hold; no pop.
- **FSM states.**
  - IDLE: after reset. Ignores lr_rise and BCLK, so a frame is never started mid-word. lr_fall → ARM(L).
  - ARM: waiting for the I2S one-bit delay. The first bclk_fall in a cycle *after* the LR edge cycle drives the MSB and goes to SHIFT with bitcnt = DATA_WIDTH−1.
  - SHIFT: each bclk_fall drives the next bit and decrements bitcnt. After the LSB has been driven, the next bclk_fall drives 0 and goes to PAD.
  - PAD: AUD_DACDAT held 0 until the next LR edge.
- **LR edges in ARM, SHIFT or PAD.** lr_rise → ARM(R); lr_fall → frame load, ARM(L).
  - An LR edge during SHIFT aborts the word; the remaining bits are dropped and AUD_DACDAT goes to 0 that cycle.
- **Simultaneous lr edge and bclk_fall.** The LR edge wins. That BCLK fall is the delay slot and shifts nothing.
- **Reset.** Takes effect immediately, including mid-word or mid-frame.
  - AUD_DACDAT=0, FIFO emptied (fifo_level=0), underrun_count=0, FSM=IDLE, synchronizer flops=0.
  - sample_ready=1; pushes are ignored while RESET is high.

## Timing
- AUD_DACDAT updates in the cycle bclk_fall is detected. That is 3 CLOCK_50 cycles after the pin edge, plus up to 1 cycle of synchronizer uncertainty.
- The codec samples on BCLK rise. Required: BCLK high and low phases each ≥6 CLOCK_50 periods.
  - At 48 kHz with 64 BCLK per frame (3.072 MHz), each phase is ~8 periods; the block must meet this.
- MSB lands on the 2nd BCLK fall after the LR edge (standard I2S one-bit delay).
- sample_ready deasserts combinationally in the cycle the FIFO becomes full. It reasserts the cycle after a pop from full.
- Push-to-audible latency: up to FIFO_DEPTH+1 frames.

## Test plan
- **Basic frame.** Reset, push {16'hA5C3, 16'h3C5A}, run a codec model at 64 BCLK/frame.
  - Left word bits read at BCLK rises 2–17 after LR fall = A5C3.
  - Right word read the same way after LR rise = 3C5A.
  - Pad bits = 0; underrun_count = 0.
- **Backpressure.** FIFO_DEPTH=4, hold sample_valid high with 6 distinct pairs.
  - sample_ready drops after the 4th push; fifo_level=4.
  - All 6 pairs are output in order over 6 frames, nothing lost.
- **Underrun.** Push nothing for 3 frames.
  - Output is all zeros; underrun_count=3.
  - After 300 empty frames, underrun_count stays at 255.
- **Startup alignment.** Release reset while DACLRCK is high mid-frame.
  - No data is driven until the first LR fall.
  - The first pushed pair appears intact in that frame.
- **Short frame.** 24 BCLK per frame (LR edge every 12 BCLK).
  - Each word is truncated to its 11 MSBs; AUD_DACDAT=0 at the edge.
  - The next frame is correctly realigned.
- **Reset mid-word.** Assert RESET during bit 7 of the left word.
  - AUD_DACDAT=0 and fifo_level=0 immediately.
  - After release, output resumes correctly at the next LR fall.
